sm3_unpad_core: RTL
===================

SM3_UNPAD_CORE -- requirements
Module: sm3_unpad_core

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have ports pad_inpt_d_i, input, 32 bits: padded-block word, big-endian byte order, word 0 of the block first.
REQ-004 SHALL have ports pad_inpt_vld_i, input, 1 bit, and pad_inpt_rdy_o, output, 1 bit: a word transfers when both are high.
REQ-005 SHALL have port pad_inpt_lst_i, input, 1 bit: marks word 15 of the final padded block.
REQ-006 SHALL have port msg_otpt_d_o, output, 32 bits: recovered message word, left-aligned.
REQ-007 SHALL have port msg_otpt_vld_byte_o, output, 4 bits: valid-byte mask, MSB = byte [31:24]; legal values 1000/1100/1110/1111.
REQ-008 SHALL have ports msg_otpt_vld_o, output, 1 bit, and msg_otpt_rdy_i, input, 1 bit: an output word transfers when both are high.
REQ-009 SHALL have port msg_otpt_lst_o, output, 1 bit: marks the final message word.
REQ-010 SHALL have port unpad_done_o, output, 1 bit: one-cycle pulse at end of each message, whether it ends normally or in error.
REQ-011 SHALL have port unpad_err_o, output, 1 bit: sticky error flag, cleared on the next accepted input word.

Function
REQ-012 SHALL buffer input in two 16x32 banks (ping-pong); word counter 0..15 selects the write address.
REQ-013 SHALL implement states RCV, EMIT_BLK, CALC, EMIT_LST.
REQ-014 RCV: pad_inpt_rdy_o=1; on word 15 accepted with lst=1 go to CALC.
- With lst=0 and no pending bank: mark the current bank pending, toggle banks, stay in RCV.
- With lst=0 and a pending bank: go to EMIT_BLK.
REQ-015 EMIT_BLK: pad_inpt_rdy_o=0; emit the 16 pending words with mask 1111 and lst=0.
- Then mark the just-completed bank pending, toggle banks, return to RCV.
REQ-016 CALC (exactly 1 cycle): bit_len = {word14, word15} of the last bank; rem_bytes = bit_len[63:3] - emitted_bytes (61-bit).
- emitted_bytes counts whole bytes already output for this message.
REQ-017 EMIT_LST: emit rem_bytes from the pending bank first (if any), then from the last bank, 4 bytes per word.
- Final word mask = 1111 if rem_bytes[1:0]==0, else the first rem_bytes[1:0] bytes; data bytes outside the mask forced to 0.
- msg_otpt_lst_o=1 on the final word; unpad_done_o pulses the cycle after that word transfers; then clear the pending flag and counters and go to RCV.
REQ-018 SHALL pulse unpad_done_o from CALC with no output words when rem_bytes==0 (empty message).
REQ-019 SHALL set unpad_err_o, emit nothing further, pulse unpad_done_o and return to RCV when any of these hold:
- bit_len[2:0]!=0;
- rem_bytes > 55 with no pending bank, or rem_bytes > 119 or < 56 with a pending bank;
- pad_inpt_lst_i=1 on a word other than word 15.
REQ-020 SHALL hold msg_otpt_d_o, msg_otpt_vld_byte_o and msg_otpt_lst_o stable while msg_otpt_vld_o=1 and msg_otpt_rdy_i=0.
REQ-021 SHALL accept no input in EMIT_BLK, CALC or EMIT_LST (pad_inpt_rdy_o=0).
REQ-022 SHALL have zero-bubble output: one word per cycle while msg_otpt_rdy_i=1.

Reset
REQ-023 SHALL, while rst=1, force state RCV and clear counters, pending flag and bank pointer.
REQ-024 SHALL reset outputs to: pad_inpt_rdy_o=0 during rst and 1 after release; msg_otpt_vld_o=0, msg_otpt_lst_o=0, msg_otpt_d_o=0, msg_otpt_vld_byte_o=0, unpad_done_o=0, unpad_err_o=0.
REQ-025 SHALL abort any in-progress message on a mid-operation reset; buffer contents are don't-care.

Configuration
REQ-026 SHALL provide macro SM3_UNPAD_FMT_CHK_EN.
- Defined: CALC additionally checks the byte after the message is 0x80, all bytes up to word 13 are 0x00, and bit_len < 2^64-512; a mismatch raises unpad_err_o per REQ-019; CALC extends to at most 17 cycles.
- Undefined: no content check, CALC is 1 cycle, and the check logic is absent.

Verification
REQ-027 "abc": block 61626380, 00000000 x13, 00000000, 00000018 with lst -> one word 61626300, mask 1110, lst=1, done pulse, err=0.
REQ-028 64 x 01020304: block 1 data, block 2 = 80000000, 0 x13, 00000000, 00000200 -> 16 words 01020304 mask 1111, lst on the 16th.
REQ-029 200-byte message (4 blocks), msg_otpt_rdy_i toggling 1/0 -> 50 words, last mask 1111, outputs stable while stalled, emitted_bytes=200.
REQ-030 Empty message: block 80000000, 0 x14, 00000000 -> no output words, done pulse, err=0.
REQ-031 Length word 00000019 -> err=1, done pulse, no lst; macro on: 61626381 in word 0 -> err=1.
REQ-032 rst asserted mid-EMIT_BLK -> msg_otpt_vld_o=0 immediately; the next "abc" message decodes per REQ-027.

Source files
------------

// File: rtl/sm3_unpad_core.sv
// sm3_unpad_core
// Strips SM3 padding from a stream of 512-bit padded blocks. The result is the
// original message as a stream of left-aligned 32-bit words with a byte mask.
//
// Ports
//   clk, rst             : clock, asynchronous active-high reset
//   pad_inpt_d_i         : padded block word (big-endian, word 0 first)
//   pad_inpt_vld_i/rdy_o : input handshake
//   pad_inpt_lst_i       : marks word 15 of the final padded block
//   msg_otpt_d_o         : recovered message word, left-aligned
//   msg_otpt_vld_byte_o  : valid-byte mask (MSB = bits [31:24])
//   msg_otpt_vld_o/rdy_i : output handshake
//   msg_otpt_lst_o       : marks the final message word
//   unpad_done_o         : one-cycle pulse at the end of every message
//   unpad_err_o          : sticky error, cleared by the next accepted input word
//
// Optional build macro SM3_UNPAD_FMT_CHK_EN: when it is defined, the block also
// scans the padding content (0x80 marker and zero fill) and the length limit
// before it emits the final words. CALC then takes up to 17 cycles.
module sm3_unpad_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pad_inpt_d_i,
    input  logic        pad_inpt_vld_i,
    output logic        pad_inpt_rdy_o,
    input  logic        pad_inpt_lst_i,
    output logic [31:0] msg_otpt_d_o,
    output logic [3:0]  msg_otpt_vld_byte_o,
    output logic        msg_otpt_vld_o,
    input  logic        msg_otpt_rdy_i,
    output logic        msg_otpt_lst_o,
    output logic        unpad_done_o,
    output logic        unpad_err_o
);

    typedef enum logic [1:0] {RCV, EMIT_BLK, CALC, EMIT_LST} state_t;

    state_t      state;
    logic [31:0] mem [2][16];
    logic        wbank;      // bank being written; the pending bank is always ~wbank
    logic        pending;
    logic [3:0]  wcnt;
    logic [3:0]  ecnt;
    logic        rd_bank;
    logic [6:0]  rem_cnt;    // bytes still to emit in EMIT_LST (at most 119)
    logic [60:0] emitted;

    logic        in_fire;
    logic        out_free;
    logic [63:0] bit_len;
    logic [60:0] rem_full;
    logic        len_bad;
    logic [31:0] rd_word;
    logic        calc_err;
    logic        calc_fin;
    logic [6:0]  calc_rem;

    assign in_fire  = pad_inpt_vld_i & pad_inpt_rdy_o;
    // The output register may be loaded when it is empty or drains this cycle.
    assign out_free = ~msg_otpt_vld_o | msg_otpt_rdy_i;
    assign bit_len  = {mem[wbank][14], mem[wbank][15]};
    assign rem_full = bit_len[63:3] - emitted;
    assign rd_word  = mem[rd_bank][ecnt];

    // If emitted exceeds the byte count, the subtraction underflows to a huge
    // value. The range check below then rejects it.
    always_comb begin
        len_bad = (bit_len[2:0] != 3'd0);
        if (pending)
            len_bad = len_bad | (rem_full > 61'd119) | (rem_full < 61'd56);
        else
            len_bad = len_bad | (rem_full > 61'd55);
    end

    function automatic logic [3:0] tail_mask(input logic [6:0] n);
        case (n)
            7'd1:    tail_mask = 4'b1000;
            7'd2:    tail_mask = 4'b1100;
            7'd3:    tail_mask = 4'b1110;
            default: tail_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] byte_expand(input logic [3:0] m);
        byte_expand = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

`ifdef SM3_UNPAD_FMT_CHK_EN
    // Scan phase: cycle scnt (1..16) checks word scnt-1 of the pending bank and
    // the same word of the last bank. Positions count from the first byte of the
    // message that is still buffered.
    logic [4:0] scnt;
    logic [3:0] k;
    logic [6:0] base_lst;
    logic       fmt_ok;

    function automatic logic word_ok(input logic [31:0] w, input logic [6:0] base,
                                     input logic [6:0] rem);
        logic [6:0] p;
        logic [7:0] b;
        word_ok = 1'b1;
        for (int j = 0; j < 4; j++) begin
            p = base + 7'(j);
            b = w[31-8*j -: 8];
            if (p == rem)
                word_ok = word_ok & (b == 8'h80);
            else if (p > rem)
                word_ok = word_ok & (b == 8'h00);
        end
    endfunction

    assign k        = 4'(scnt - 5'd1);
    assign base_lst = pending ? (7'd64 + {1'b0, k, 2'b00}) : {1'b0, k, 2'b00};

    always_comb begin
        fmt_ok = 1'b1;
        if (pending && !word_ok(mem[~wbank][k], {1'b0, k, 2'b00}, rem_cnt))
            fmt_ok = 1'b0;
        if (k <= 4'd13 && !word_ok(mem[wbank][k], base_lst, rem_cnt))
            fmt_ok = 1'b0;
    end

    always_comb begin
        calc_rem = rem_cnt;
        calc_fin = (scnt == 5'd16);
        if (scnt == 5'd0)
            calc_err = len_bad | (bit_len >= 64'hFFFF_FFFF_FFFF_FE00);
        else
            calc_err = ~fmt_ok;
    end
`else
    assign calc_rem = rem_full[6:0];
    assign calc_err = len_bad;
    assign calc_fin = 1'b1;
`endif

    // Buffer storage is not reset; its contents do not matter after reset.
    always_ff @(posedge clk) begin
        if (in_fire)
            mem[wbank][wcnt] <= pad_inpt_d_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= RCV;
            pad_inpt_rdy_o      <= 1'b0;
            wbank               <= 1'b0;
            pending             <= 1'b0;
            wcnt                <= 4'd0;
            ecnt                <= 4'd0;
            rd_bank             <= 1'b0;
            rem_cnt             <= 7'd0;
            emitted             <= 61'd0;
            msg_otpt_d_o        <= 32'd0;
            msg_otpt_vld_byte_o <= 4'd0;
            msg_otpt_vld_o      <= 1'b0;
            msg_otpt_lst_o      <= 1'b0;
            unpad_done_o        <= 1'b0;
            unpad_err_o         <= 1'b0;
`ifdef SM3_UNPAD_FMT_CHK_EN
            scnt                <= 5'd0;
`endif
        end else begin
            unpad_done_o <= 1'b0;
            if (msg_otpt_vld_o && msg_otpt_rdy_i)
                msg_otpt_vld_o <= 1'b0;

            case (state)
                RCV: begin
                    pad_inpt_rdy_o <= 1'b1;
`ifdef SM3_UNPAD_FMT_CHK_EN
                    scnt <= 5'd0;
`endif
                    if (in_fire) begin
                        unpad_err_o <= 1'b0;
                        wcnt        <= wcnt + 4'd1;
                        if (pad_inpt_lst_i && wcnt != 4'd15) begin
                            // A truncated final block drops the whole message.
                            unpad_err_o  <= 1'b1;
                            unpad_done_o <= 1'b1;
                            pending      <= 1'b0;
                            emitted      <= 61'd0;
                            wcnt         <= 4'd0;
                        end else if (wcnt == 4'd15) begin
                            if (pad_inpt_lst_i) begin
                                state          <= CALC;
                                pad_inpt_rdy_o <= 1'b0;
                            end else if (!pending) begin
                                pending <= 1'b1;
                                wbank   <= ~wbank;
                            end else begin
                                state          <= EMIT_BLK;
                                pad_inpt_rdy_o <= 1'b0;
                                rd_bank        <= ~wbank;
                                ecnt           <= 4'd0;
                            end
                        end
                    end
                end

                EMIT_BLK: begin
                    if (out_free) begin
                        msg_otpt_vld_o      <= 1'b1;
                        msg_otpt_d_o        <= rd_word;
                        msg_otpt_vld_byte_o <= 4'b1111;
                        msg_otpt_lst_o      <= 1'b0;
                        emitted             <= emitted + 61'd4;
                        ecnt                <= ecnt + 4'd1;
                        // The last word is already in the output register, so
                        // the drained bank can be refilled at once. The bank just
                        // filled becomes the pending one.
                        if (ecnt == 4'd15) begin
                            state          <= RCV;
                            pad_inpt_rdy_o <= 1'b1;
                            wbank          <= ~wbank;
                        end
                    end
                end

                CALC: begin
                    if (calc_err) begin
                        unpad_err_o    <= 1'b1;
                        unpad_done_o   <= 1'b1;
                        state          <= RCV;
                        pad_inpt_rdy_o <= 1'b1;
                        pending        <= 1'b0;
                        emitted        <= 61'd0;
                    end else if (calc_fin) begin
                        if (calc_rem == 7'd0) begin
                            unpad_done_o   <= 1'b1;
                            state          <= RCV;
                            pad_inpt_rdy_o <= 1'b1;
                            pending        <= 1'b0;
                            emitted        <= 61'd0;
                        end else begin
                            state   <= EMIT_LST;
                            rem_cnt <= calc_rem;
                            rd_bank <= pending ? ~wbank : wbank;
                            ecnt    <= 4'd0;
                        end
                    end
`ifdef SM3_UNPAD_FMT_CHK_EN
                    else begin
                        if (scnt == 5'd0)
                            rem_cnt <= rem_full[6:0];
                        scnt <= scnt + 5'd1;
                    end
`endif
                end

                EMIT_LST: begin
                    if (msg_otpt_lst_o) begin
                        if (msg_otpt_vld_o && msg_otpt_rdy_i) begin
                            unpad_done_o   <= 1'b1;
                            msg_otpt_lst_o <= 1'b0;
                            state          <= RCV;
                            pad_inpt_rdy_o <= 1'b1;
                            pending        <= 1'b0;
                            emitted        <= 61'd0;
                            ecnt           <= 4'd0;
                        end
                    end else if (out_free) begin
                        msg_otpt_vld_o <= 1'b1;
                        if (rem_cnt <= 7'd4) begin
                            msg_otpt_vld_byte_o <= tail_mask(rem_cnt);
                            msg_otpt_d_o        <= rd_word & byte_expand(tail_mask(rem_cnt));
                            msg_otpt_lst_o      <= 1'b1;
                        end else begin
                            msg_otpt_vld_byte_o <= 4'b1111;
                            msg_otpt_d_o        <= rd_word;
                            rem_cnt             <= rem_cnt - 7'd4;
                            ecnt                <= ecnt + 4'd1;
                            // After the pending bank, continue with the last bank.
                            if (ecnt == 4'd15)
                                rd_bank <= wbank;
                        end
                    end
                end

                default: state <= RCV;
            endcase
        end
    end

endmodule
